// File: rtl/mux2to1_stream.sv
// mux2to1_stream: merges two valid/ready channels into one registered output
// stream. Each output word carries its source channel in out_sel.
// A one-entry output register (EMPTY/FULL) gives single-cycle latency and
// full throughput when out_ready is held high.
// Build option: define MUX2TO1_RR_EN for round-robin conflict resolution.
// Without it, in0 has fixed priority over in1.
module mux2to1_stream #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel,
   input  logic             out_ready
);

`ifdef MUX2TO1_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic             r_sel;
   logic             r_last_grant;

   logic             w_slot_free;
   logic             w_en;
   logic             w_pick1;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;
   logic [WIDTH-1:0] w_acc_data;

   // Pick a channel: a lone requester always wins; on conflict round-robin
   // hands the grant to the channel that did not win last time, while the
   // fixed-priority build always favours in0. Readies are held low during
   // reset and whenever the output slot cannot take a new word.
   always_comb begin
      w_slot_free = (r_state == ST_EMPTY) || out_ready;
      w_en        = rst_n && w_slot_free;
      if (in0_valid && in1_valid)
         w_pick1 = RR_EN ? !r_last_grant : 1'b0;
      else
         w_pick1 = in1_valid;
      w_gnt0     = w_en && in0_valid && !w_pick1;
      w_gnt1     = w_en && in1_valid &&  w_pick1;
      w_accept   = w_gnt0 || w_gnt1;
      w_acc_data = w_gnt1 ? in1_data : in0_data;
   end

   assign in0_ready = w_gnt0;
   assign in1_ready = w_gnt1;

   // Output slot state machine: load on any accept, drain on an output
   // transfer with no refill; data/sel only change when a word is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_EMPTY;
         r_data       <= '0;
         r_sel        <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) r_state <= ST_FULL;
            end
            ST_FULL: begin
               if (out_ready && !w_accept) r_state <= ST_EMPTY;
            end
            default: r_state <= ST_EMPTY;
         endcase
         if (w_accept) begin
            r_data       <= w_acc_data;
            r_sel        <= w_gnt1;
            r_last_grant <= w_gnt1;
         end
      end
   end

   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_data;
   assign out_sel   = r_sel;

endmodule
